mem_allocator: RTL and testbench
================================

# mem_allocator

Memory-side responder for the load/store buffer and instruction fetch. Accepts word/half/byte read and write requests from the load/store buffer and 4-byte fetch requests from the fetch unit, arbitrates between them, and serialises each access onto the 8-bit single-port RAM/IO bus. Returns a one-cycle grant pulse when a request is taken and a one-cycle done pulse, with read data, when it completes.

## Interface
Parameters:
- `IoHiAddr`, default 2'b11: value of address bits [17:16] that selects the IO region.

Ports:
- `clk_in`  in  1  clock
- `rst_in`  in  1  synchronous, active-high reset
- `rdy_in`  in  1  global ready; low freezes all state
- `clear_branch_in`  in  1  misprediction flush; aborts a pending or in-flight fetch only
- `lsb_to_alloc_r_en_in`  in  1  load request, held until grant
- `lsb_to_alloc_w_en_in`  in  1  store request, held until grant
- `lsb_a_in`  in  32  byte address for the load or store
- `lsb_r_offset_in`, `lsb_w_offset_in`  in  2  bytes − 1 (0 = byte, 1 = half, 3 = word)
- `lsb_d_in`  in  32  store data, little-endian, low bytes used
- `alloc_to_lsb_r_gr_out`, `alloc_to_lsb_w_gr_out`  out  1  grant pulses
- `alloc_to_lsb_r_en_out`, `alloc_to_lsb_w_en_out`  out  1  done pulses
- `lsb_d_out`  out  32  load data, zero-extended; valid with r done
- `if_to_alloc_en_in`  in  1  fetch request, held until grant
- `if_a_in`  in  32  fetch address
- `alloc_to_if_gr_out`, `alloc_to_if_en_out`  out  1  fetch grant and done pulses
- `if_d_out`  out  32  fetched instruction
- `mem_din`  in  8  RAM/IO read byte; one-cycle latency after `mem_a`
- `mem_dout`  out  8  write byte
- `mem_a`  out  32  byte address
- `mem_wr`  out  1  1 = write
- `io_buffer_full`  in  1  IO output FIFO full

## Operation
- FSM states: IDLE, READ, WRITE, WAIT_IO, FETCH. Byte counter `cnt` (3 bits), latched address, length (`offset`+1), and data shift register.
- IDLE arbitration, fixed priority: store > load > fetch. The winner's grant pulses for exactly one cycle; the other requests stay pending.
- READ/FETCH: issue `mem_a = base + cnt` for cnt = 0..len−1 with `mem_wr = 0`. Byte i lands in bits [8i+7:8i]. Unfetched upper bytes are 0.
- WRITE: drive `mem_a = base + cnt`, `mem_dout = byte cnt`, and `mem_wr = 1` for len cycles, then pulse w done.
- A store with addr[17:16] == `IoHiAddr` while `io_buffer_full` is high enters WAIT_IO with `mem_wr = 0`. It proceeds to WRITE in the cycle after full drops.
- Sign extension is done by the requester, not here.
- `clear_branch_in` aborts a FETCH: return to IDLE next cycle, with no if done pulse and no bus write. A pending (ungranted) fetch is also dropped. Granted loads and stores always complete; their done pulse is issued even during a clear.
- `rdy_in` low: no register updates, and `mem_wr` is forced to 0.
- Reset: state IDLE, `cnt` 0. All grant/done pulses 0, `mem_wr` 0, `mem_a` 0, `mem_dout` 0, and all data outputs 0.

## Timing
- Request sampled high in IDLE at edge E0; grant is high during cycle 1, which is the first address cycle.
- Read of N bytes: addresses in cycles 1..N, and byte i is sampled at the end of cycle i+2. Done and data are valid during cycle N+2. Load word latency is 6 cycles from request; a fetch is always 6.
- Write of N bytes: `mem_wr` is high in cycles 1..N, and done is high in cycle N+1.
- FSM is back in IDLE in the done cycle, so a new request is sampled that cycle. Back-to-back accesses therefore have a one-cycle bubble.
- Data outputs hold their value until the next done of the same port.
- Address arithmetic is 32-bit wrap-around.

## Structure
- Add state encodings, `IoHiAddr`, and the width macros `AddrWidth`, `WordWidth`, and `WordBytesWidth` to the shared `config.vh`.
- Single module. An optional sub-module `byte_serializer` (counter + shift register) can be shared by the read and write paths.

## Test plan
- Load word at 0x100 with RAM bytes 11 22 33 44 -> r grant in cycle 1, r done in cycle 6, `lsb_d_out` = 0x44332211.
- Store half 0xBEEF at 0x2 -> `mem_wr` high 2 cycles with (0x2, EF) then (0x3, BE), w done in cycle 3.
- Store, load, and fetch requested in the same cycle -> grant order is store, then load, then fetch; each done arrives before the next grant.
- Fetch in flight, `clear_branch_in` pulsed in cycle 3 -> IDLE next cycle, no if done, a following load is granted immediately.
- Store byte 0x41 to 0x30000 with `io_buffer_full` high for 5 cycles -> `mem_wr` stays 0, then one write cycle, then done.
- Reset asserted mid-read -> all outputs 0 next cycle, no done pulse; a subsequent load completes normally.

Source files
------------

// File: rtl/mem_allocator_pkg.sv
// Shared widths, state encoding and IO region default for the memory allocator.
package mem_allocator_pkg;

   localparam int AddrWidth      = 32;
   localparam int WordWidth      = 32;
   localparam int WordBytesWidth = 3;   // holds 0..4: byte count of a word access

   localparam logic [1:0] IO_HI_ADDR_DEF = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_WAIT_IO,
      ST_FETCH
   } state_t;

endpackage

// File: rtl/mem_allocator.sv
// Arbitrates load/store and fetch requests and serialises each access onto
// the 8-bit RAM/IO bus, one byte per cycle.
module mem_allocator
   import mem_allocator_pkg::*;
#(
   parameter logic [1:0] IoHiAddr = IO_HI_ADDR_DEF
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 clear_branch_in,
   input  logic                 lsb_to_alloc_r_en_in,
   input  logic                 lsb_to_alloc_w_en_in,
   input  logic [AddrWidth-1:0] lsb_a_in,
   input  logic [1:0]           lsb_r_offset_in,
   input  logic [1:0]           lsb_w_offset_in,
   input  logic [WordWidth-1:0] lsb_d_in,
   output logic                 alloc_to_lsb_r_gr_out,
   output logic                 alloc_to_lsb_w_gr_out,
   output logic                 alloc_to_lsb_r_en_out,
   output logic                 alloc_to_lsb_w_en_out,
   output logic [WordWidth-1:0] lsb_d_out,
   input  logic                 if_to_alloc_en_in,
   input  logic [AddrWidth-1:0] if_a_in,
   output logic                 alloc_to_if_gr_out,
   output logic                 alloc_to_if_en_out,
   output logic [WordWidth-1:0] if_d_out,
   input  logic [7:0]           mem_din,
   output logic [7:0]           mem_dout,
   output logic [AddrWidth-1:0] mem_a,
   output logic                 mem_wr,
   input  logic                 io_buffer_full
);

   state_t                    state, state_nxt;
   logic [WordBytesWidth-1:0] cnt, len;
   logic [AddrWidth-1:0]      base;
   logic [WordWidth-1:0]      data, rd_merge;
   logic [1:0]                rd_idx;
   logic                      take_w, take_r, take_if, fin, is_io, issue;
   logic                      r_gr, w_gr, if_gr, r_done, w_done, if_done;
   logic [WordWidth-1:0]      lsb_d, if_d;

   assign is_io  = (lsb_a_in[17:16] == IoHiAddr);
   // In a read, the byte arriving now was addressed one cycle earlier.
   assign rd_idx = cnt[1:0] - 2'd1;

   // State register; rdy_in low freezes it.
   always_ff @(posedge clk_in) begin
      if (rst_in)
         state <= ST_IDLE;
      else if (rdy_in)
         state <= state_nxt;
   end

   // Next state, arbitration (store > load > fetch) and completion detect.
   always_comb begin
      state_nxt = state;
      take_w    = 1'b0;
      take_r    = 1'b0;
      take_if   = 1'b0;
      fin       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (lsb_to_alloc_w_en_in) begin
               take_w    = 1'b1;
               state_nxt = (is_io && io_buffer_full) ? ST_WAIT_IO : ST_WRITE;
            end else if (lsb_to_alloc_r_en_in) begin
               take_r    = 1'b1;
               state_nxt = ST_READ;
            end else if (if_to_alloc_en_in && !clear_branch_in) begin
               take_if   = 1'b1;
               state_nxt = ST_FETCH;
            end
         end
         ST_WAIT_IO: begin
            if (!io_buffer_full)
               state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            if (cnt == len - 3'd1) begin
               fin       = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_READ: begin
            if (cnt == len) begin
               fin       = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_FETCH: begin
            // A flush kills the fetch outright; no done pulse follows.
            if (clear_branch_in) begin
               state_nxt = ST_IDLE;
            end else if (cnt == len) begin
               fin       = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Read data with the byte currently on mem_din merged in.
   always_comb begin
      rd_merge = data;
      if (cnt != '0)
         rd_merge[{rd_idx, 3'b000} +: 8] = mem_din;
   end

   // Datapath: request capture, byte counter, read assembly, pulses.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cnt     <= '0;
         len     <= '0;
         base    <= '0;
         data    <= '0;
         r_gr    <= 1'b0;
         w_gr    <= 1'b0;
         if_gr   <= 1'b0;
         r_done  <= 1'b0;
         w_done  <= 1'b0;
         if_done <= 1'b0;
         lsb_d   <= '0;
         if_d    <= '0;
      end else if (rdy_in) begin
         r_gr    <= 1'b0;
         w_gr    <= 1'b0;
         if_gr   <= 1'b0;
         r_done  <= 1'b0;
         w_done  <= 1'b0;
         if_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (take_w) begin
                  base <= lsb_a_in;
                  len  <= {1'b0, lsb_w_offset_in} + 3'd1;
                  data <= lsb_d_in;
                  w_gr <= 1'b1;
               end else if (take_r) begin
                  base <= lsb_a_in;
                  len  <= {1'b0, lsb_r_offset_in} + 3'd1;
                  data <= '0;
                  r_gr <= 1'b1;
               end else if (take_if) begin
                  base  <= if_a_in;
                  len   <= 3'd4;
                  data  <= '0;
                  if_gr <= 1'b1;
               end
            end
            ST_READ, ST_FETCH: begin
               cnt  <= cnt + 3'd1;
               data <= rd_merge;
               if (fin) begin
                  if (state == ST_READ) begin
                     r_done <= 1'b1;
                     lsb_d  <= rd_merge;
                  end else begin
                     if_done <= 1'b1;
                     if_d    <= rd_merge;
                  end
               end
            end
            ST_WRITE: begin
               cnt <= cnt + 3'd1;
               if (fin)
                  w_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Bus drive: address only while a byte is actually being moved.
   always_comb begin
      issue = ((state == ST_READ || state == ST_FETCH) && cnt < len) ||
              (state == ST_WRITE);
      mem_a    = issue ? base + {{(AddrWidth-WordBytesWidth){1'b0}}, cnt} : '0;
      mem_wr   = rdy_in && (state == ST_WRITE);
      mem_dout = (state == ST_WRITE) ? data[{cnt[1:0], 3'b000} +: 8] : 8'h00;
   end

   assign alloc_to_lsb_r_gr_out = r_gr;
   assign alloc_to_lsb_w_gr_out = w_gr;
   assign alloc_to_lsb_r_en_out = r_done;
   assign alloc_to_lsb_w_en_out = w_done;
   assign alloc_to_if_gr_out    = if_gr;
   assign alloc_to_if_en_out    = if_done;
   assign lsb_d_out             = lsb_d;
   assign if_d_out              = if_d;

endmodule

// File: tb/tb_mem_allocator.sv
// Directed bench for mem_allocator with a one-cycle-latency byte RAM model.
module tb_mem_allocator;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, clear_branch_in;
   logic        lsb_to_alloc_r_en_in, lsb_to_alloc_w_en_in;
   logic [31:0] lsb_a_in, lsb_d_in, if_a_in;
   logic [1:0]  lsb_r_offset_in, lsb_w_offset_in;
   logic        alloc_to_lsb_r_gr_out, alloc_to_lsb_w_gr_out;
   logic        alloc_to_lsb_r_en_out, alloc_to_lsb_w_en_out;
   logic [31:0] lsb_d_out, if_d_out, mem_a;
   logic        if_to_alloc_en_in, alloc_to_if_gr_out, alloc_to_if_en_out;
   logic [7:0]  mem_din, mem_dout;
   logic        mem_wr, io_buffer_full;

   logic [7:0]  ram [0:4095];
   logic [39:0] wlog [$];

   int n_chk = 0, n_fail = 0;
   int f_rgr, f_wgr, f_ifgr, f_rdone, f_wdone, f_ifdone, f_wr;
   int n_rdone, n_wdone, n_ifdone, n_wr;
   logic [31:0] a_c1;

   mem_allocator dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .clear_branch_in(clear_branch_in),
      .lsb_to_alloc_r_en_in(lsb_to_alloc_r_en_in),
      .lsb_to_alloc_w_en_in(lsb_to_alloc_w_en_in),
      .lsb_a_in(lsb_a_in), .lsb_r_offset_in(lsb_r_offset_in),
      .lsb_w_offset_in(lsb_w_offset_in), .lsb_d_in(lsb_d_in),
      .alloc_to_lsb_r_gr_out(alloc_to_lsb_r_gr_out),
      .alloc_to_lsb_w_gr_out(alloc_to_lsb_w_gr_out),
      .alloc_to_lsb_r_en_out(alloc_to_lsb_r_en_out),
      .alloc_to_lsb_w_en_out(alloc_to_lsb_w_en_out),
      .lsb_d_out(lsb_d_out), .if_to_alloc_en_in(if_to_alloc_en_in),
      .if_a_in(if_a_in), .alloc_to_if_gr_out(alloc_to_if_gr_out),
      .alloc_to_if_en_out(alloc_to_if_en_out), .if_d_out(if_d_out),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
      .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
   );

   always #5 clk_in = ~clk_in;

   // RAM model: read data one cycle after address; log every write cycle.
   always @(posedge clk_in) begin
      mem_din <= ram[mem_a[11:0]];
      if (mem_wr) begin
         ram[mem_a[11:0]] <= mem_dout;
         wlog.push_back({mem_a, mem_dout});
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   // Run ncyc cycles after the request edge, acting as requester (drop on
   // grant) and recording the first cycle of each pulse.
   task automatic watch(input int ncyc, input int full_until);
      f_rgr = 0; f_wgr = 0; f_ifgr = 0; f_rdone = 0; f_wdone = 0; f_ifdone = 0;
      f_wr = 0; n_rdone = 0; n_wdone = 0; n_ifdone = 0; n_wr = 0; a_c1 = 'x;
      for (int k = 1; k <= ncyc; k++) begin
         step();
         io_buffer_full = (k < full_until);
         if (k == 1) a_c1 = mem_a;
         if (alloc_to_lsb_w_gr_out) begin if (f_wgr == 0) f_wgr = k; lsb_to_alloc_w_en_in = 0; end
         if (alloc_to_lsb_r_gr_out) begin if (f_rgr == 0) f_rgr = k; lsb_to_alloc_r_en_in = 0; end
         if (alloc_to_if_gr_out)    begin if (f_ifgr == 0) f_ifgr = k; if_to_alloc_en_in = 0; end
         if (alloc_to_lsb_w_en_out) begin n_wdone++;  if (f_wdone == 0) f_wdone = k; end
         if (alloc_to_lsb_r_en_out) begin n_rdone++;  if (f_rdone == 0) f_rdone = k; end
         if (alloc_to_if_en_out)    begin n_ifdone++; if (f_ifdone == 0) f_ifdone = k; end
         if (mem_wr)                begin n_wr++;     if (f_wr == 0) f_wr = k; end
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
      ram[12'h100] = 8'h11; ram[12'h101] = 8'h22;
      ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
      rst_in = 1; rdy_in = 1; clear_branch_in = 0;
      lsb_to_alloc_r_en_in = 0; lsb_to_alloc_w_en_in = 0; if_to_alloc_en_in = 0;
      lsb_a_in = 0; lsb_d_in = 0; if_a_in = 0; lsb_r_offset_in = 0; lsb_w_offset_in = 0;
      io_buffer_full = 0;

      // reset state
      step(); step();
      chk("rst_mem_a", mem_a, 0);
      chk("rst_mem_wr", {31'b0, mem_wr}, 0);
      chk("rst_lsb_d", lsb_d_out, 0);
      chk("rst_pulses", {26'b0, alloc_to_lsb_r_gr_out, alloc_to_lsb_w_gr_out,
          alloc_to_lsb_r_en_out, alloc_to_lsb_w_en_out, alloc_to_if_gr_out, alloc_to_if_en_out}, 0);
      rst_in = 0;
      step();

      // load word at 0x100
      lsb_a_in = 32'h100; lsb_r_offset_in = 2'd3; lsb_to_alloc_r_en_in = 1;
      watch(8, 0);
      chk("ldw_gr", f_rgr, 1);
      chk("ldw_a1", a_c1, 32'h100);
      chk("ldw_done", f_rdone, 6);
      chk("ldw_ndone", n_rdone, 1);
      chk("ldw_data", lsb_d_out, 32'h44332211);

      // store half 0xBEEF at 0x2
      wlog.delete();
      lsb_a_in = 32'h2; lsb_w_offset_in = 2'd1; lsb_d_in = 32'h0000BEEF; lsb_to_alloc_w_en_in = 1;
      watch(6, 0);
      chk("sth_gr", f_wgr, 1);
      chk("sth_wr_first", f_wr, 1);
      chk("sth_nwr", n_wr, 2);
      chk("sth_done", f_wdone, 3);
      chk("sth_nlog", wlog.size(), 2);
      if (wlog.size() == 2) begin
         chk("sth_w0", wlog[0], 40'h00000002EF);
         chk("sth_w1", wlog[1], 40'h00000003BE);
      end

      // store byte, load byte, fetch word all at once
      lsb_a_in = 32'h10; lsb_w_offset_in = 2'd0; lsb_r_offset_in = 2'd0; lsb_d_in = 32'h5A;
      if_a_in = 32'h100;
      lsb_to_alloc_w_en_in = 1; lsb_to_alloc_r_en_in = 1; if_to_alloc_en_in = 1;
      watch(14, 0);
      chk("arb_wgr", f_wgr, 1);
      chk("arb_wdone", f_wdone, 2);
      chk("arb_rgr", f_rgr, 3);
      chk("arb_rdone", f_rdone, 5);
      chk("arb_ifgr", f_ifgr, 6);
      chk("arb_ifdone", f_ifdone, 11);
      chk("arb_ld", lsb_d_out, 32'h5A);
      chk("arb_if", if_d_out, 32'h44332211);

      // rdy low during a store freezes it and blocks the bus write
      wlog.delete();
      lsb_a_in = 32'h20; lsb_w_offset_in = 2'd1; lsb_d_in = 32'h1234; lsb_to_alloc_w_en_in = 1;
      step();
      chk("rdy_gr", {31'b0, alloc_to_lsb_w_gr_out}, 1);
      lsb_to_alloc_w_en_in = 0;
      rdy_in = 0;
      #1;
      chk("rdy_wr_forced", {31'b0, mem_wr}, 0);
      step();
      chk("rdy_frozen_done", {31'b0, alloc_to_lsb_w_en_out}, 0);
      rdy_in = 1;
      step(); step();
      chk("rdy_done", {31'b0, alloc_to_lsb_w_en_out}, 1);
      chk("rdy_nlog", wlog.size(), 2);
      if (wlog.size() == 2) begin
         chk("rdy_w0", wlog[0], 40'h0000002034);
         chk("rdy_w1", wlog[1], 40'h0000002112);
      end

      // IO store held off by a full buffer
      wlog.delete();
      lsb_a_in = 32'h30000; lsb_w_offset_in = 2'd0; lsb_d_in = 32'h41;
      io_buffer_full = 1; lsb_to_alloc_w_en_in = 1;
      watch(10, 5);
      chk("io_gr", f_wgr, 1);
      chk("io_wr_first", f_wr, 6);
      chk("io_nwr", n_wr, 1);
      chk("io_done", f_wdone, 7);
      chk("io_nlog", wlog.size(), 1);
      if (wlog.size() == 1) chk("io_w0", wlog[0], 40'h0003000041);

      // reset in the middle of a read
      lsb_a_in = 32'h100; lsb_r_offset_in = 2'd3; lsb_to_alloc_r_en_in = 1;
      step();
      lsb_to_alloc_r_en_in = 0;
      step(); step();
      rst_in = 1;
      step();
      chk("mrst_mem_a", mem_a, 0);
      chk("mrst_lsb_d", lsb_d_out, 0);
      chk("mrst_if_d", if_d_out, 0);
      chk("mrst_outs", {22'b0, mem_dout, mem_wr, alloc_to_lsb_r_en_out}, 0);
      rst_in = 0;
      watch(6, 0);
      chk("mrst_nodone", n_rdone, 0);
      lsb_a_in = 32'h102; lsb_r_offset_in = 2'd1; lsb_to_alloc_r_en_in = 1;
      watch(6, 0);
      chk("mrst_ld_gr", f_rgr, 1);
      chk("mrst_ld_done", f_rdone, 4);
      chk("mrst_ld_data", lsb_d_out, 32'h4433);

      // pending fetch dropped by a flush
      if_a_in = 32'h100; if_to_alloc_en_in = 1; clear_branch_in = 1;
      step();
      chk("drop_ifgr", {31'b0, alloc_to_if_gr_out}, 0);
      if_to_alloc_en_in = 0; clear_branch_in = 0;
      step();

      // in-flight fetch aborted in cycle 3, load follows immediately
      if_to_alloc_en_in = 1;
      step();
      chk("abt_ifgr", {31'b0, alloc_to_if_gr_out}, 1);
      if_to_alloc_en_in = 0;
      step(); step();
      clear_branch_in = 1;
      lsb_a_in = 32'h100; lsb_r_offset_in = 2'd3; lsb_to_alloc_r_en_in = 1;
      step();
      clear_branch_in = 0;
      chk("abt_idle_a", mem_a, 0);
      watch(8, 0);
      chk("abt_ld_gr", f_rgr, 1);
      chk("abt_ld_done", f_rdone, 6);
      chk("abt_noifdone", n_ifdone, 0);
      chk("abt_ld_data", lsb_d_out, 32'h44332211);

      $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
      $finish;
   end

endmodule
